// File: rtl/sr_arb_pkg.sv
// Shared types and defaults for the SR register write arbiter.
package sr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NREGS  = 4;
  localparam int DEF_ADDR_W = 2;

  // Index width for n requesters; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority pick: first asserted request at or above base, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
module rr_picker
  import sr_arb_pkg::*;
#(
  parameter int N = DEF_NREQ,
  parameter int W = ptr_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic         vld,
  output logic [W-1:0] idx
);

  int best;

  // Keep the requester with the smallest rotational distance from base.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (((i - int'(base) + N) % N) < best)) begin
        best = (i - int'(base) + N) % N;
        vld  = 1'b1;
        idx  = W'(i);
      end
    end
  end

endmodule

// File: rtl/sr_reg_write_arbiter.sv
// Round-robin owner of the SR register bank write port: drive S/R one cycle, verify readback, ack.
// Latency: grant edge -> DRIVE one cycle -> CHECK one cycle (ack) -> IDLE; one write per 3 cycles.
// Backpressure: requesters hold req until ack; losers wait, nothing is dropped.
module sr_reg_write_arbiter
  import sr_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic [WIDTH-1:0]         s_out,
  output logic [WIDTH-1:0]         r_out,
  output logic [NREGS-1:0]         reg_sel,
  input  logic [WIDTH-1:0]         q_in,
  output logic                     err,
  output logic [$clog2(NREQ)-1:0]  err_id,
  input  logic                     err_clr
);

  localparam int PW = ptr_w(NREQ);

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WIDTH-1:0]    data_q;
  logic                pick_vld;
  logic [PW-1:0]       pick_id;
  logic                mismatch;

  rr_picker #(
    .N (NREQ),
    .W (PW)
  ) u_pick (
    .req  (req),
    .base (ptr_q),
    .vld  (pick_vld),
    .idx  (pick_id)
  );

  // Outputs decode from state flops only, so an async reset zeroes them at once.
  always_comb begin
    state_d = state_q;
    s_out   = '0;
    r_out   = '0;
    reg_sel = '0;
    ack     = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) state_d = DRIVE;
      end
      DRIVE: begin
        s_out   = data_q;
        r_out   = ~data_q;
        reg_sel = NREGS'(1) << addr_q;
        state_d = CHECK;
      end
      CHECK: begin
        ack     = NREQ'(1) << id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign mismatch = (state_q == CHECK) && (q_in != data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_vld) begin
        id_q   <= pick_id;
        addr_q <= req_addr[pick_id*ADDR_W +: ADDR_W];
        data_q <= req_data[pick_id*WIDTH +: WIDTH];
      end
      if (state_q == CHECK) begin
        ptr_q <= (id_q == PW'(NREQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

  // A mismatch in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err    <= 1'b0;
      err_id <= '0;
    end else if (mismatch) begin
      err    <= 1'b1;
      err_id <= id_q;
    end else if (err_clr) begin
      err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_reg_write_arbiter.sv
// Bench for sr_reg_write_arbiter with a behavioural SR bank and request-level reference model.
module tb_sr_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  s_out, r_out;
  logic [3:0]  reg_sel;
  logic [7:0]  q_in;
  logic        err;
  logic [1:0]  err_id;
  logic        err_clr = 1'b0;

  sr_reg_write_arbiter #(.NREQ(4), .WIDTH(8), .NREGS(4), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .busy(busy), .s_out(s_out), .r_out(r_out), .reg_sel(reg_sel),
    .q_in(q_in), .err(err), .err_id(err_id), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SR flip-flop bank: Q' = (Q & ~R) | S on enabled registers.
  logic [7:0] bank [4] = '{default: 8'h00};
  logic [1:0] last_addr = '0;
  logic       force_q = 1'b0;
  logic [7:0] force_val = '0;
  assign q_in = force_q ? force_val : bank[last_addr];

  always @(posedge clk) begin
    for (int a = 0; a < 4; a++) begin
      if (reg_sel[a]) begin
        bank[a]   <= (bank[a] & ~r_out) | s_out;
        last_addr <= 2'(a);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) check("s_and_r_zero", {24'h0, s_out & r_out}, 32'h0);
  end

  // Request-level reference model: who wins, when, and what gets written.
  bit         rand_on = 1'b0;
  int         m_phase = 0;
  int         m_ptr = 0;
  int         m_win = 0;
  int         m_sel;
  logic [1:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic [7:0] m_mem [4];
  bit         m_written [4];
  bit         m_done [4];

  always @(posedge clk) begin
    if (rand_on) begin
      if (m_phase == 0) begin
        m_sel = -1;
        for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) m_sel = (m_ptr + k) % 4;
        if (m_sel >= 0) begin
          m_win  = m_sel;
          m_addr = req_addr[m_sel*2 +: 2];
          m_data = req_data[m_sel*8 +: 8];
          m_mem[m_addr]     = m_data;
          m_written[m_addr] = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        m_phase = 0;
        m_ptr   = (m_win + 1) % 4;
        m_done[m_win] = 1'b1;
      end
    end
  end

  logic [7:0] e_s, e_r;
  logic [3:0] e_sel, e_ack;
  always @(negedge clk) begin
    if (rand_on) begin
      e_s   = (m_phase == 1) ? m_data : 8'h00;
      e_r   = (m_phase == 1) ? ~m_data : 8'h00;
      e_sel = (m_phase == 1) ? (4'b0001 << m_addr) : 4'b0000;
      e_ack = (m_phase == 2) ? (4'b0001 << m_win) : 4'b0000;
      check("rnd_busy", busy, (m_phase != 0));
      check("rnd_ack", ack, e_ack);
      check("rnd_s_out", s_out, e_s);
      check("rnd_r_out", r_out, e_r);
      check("rnd_reg_sel", reg_sel, e_sel);
      check("rnd_err", err, 1'b0);
    end
  end

  task automatic do_reset();
    req = '0; err_clr = 1'b0; force_q = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         id;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] s;
    logic [7:0] r;
    logic [3:0] sel;
    logic [3:0] ackv;
  } vec_t;

  vec_t tv [4];
  int   ord [$];
  int   at [$];

  initial begin
    tv[0] = '{0, 2'd2, 8'hA5, 8'hA5, 8'h5A, 4'b0100, 4'b0001};
    tv[1] = '{1, 2'd0, 8'h0F, 8'h0F, 8'hF0, 4'b0001, 4'b0010};
    tv[2] = '{2, 2'd3, 8'h00, 8'h00, 8'hFF, 4'b1000, 4'b0100};
    tv[3] = '{3, 2'd1, 8'hC3, 8'hC3, 8'h3C, 4'b0010, 4'b1000};

    do_reset();
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_s_out", s_out, 0);
    check("rst_r_out", r_out, 0);
    check("rst_reg_sel", reg_sel, 0);
    check("rst_err", err, 0);
    check("rst_err_id", err_id, 0);

    // Single writes from a table.
    foreach (tv[v]) begin
      req_addr[tv[v].id*2 +: 2] = tv[v].addr;
      req_data[tv[v].id*8 +: 8] = tv[v].data;
      req[tv[v].id] = 1'b1;
      step();
      check("vec_drive_s", s_out, tv[v].s);
      check("vec_drive_r", r_out, tv[v].r);
      check("vec_drive_sel", reg_sel, tv[v].sel);
      check("vec_drive_busy", busy, 1);
      check("vec_drive_ack", ack, 0);
      step();
      check("vec_check_ack", ack, tv[v].ackv);
      check("vec_check_sel", reg_sel, 0);
      check("vec_check_err", err, 0);
      req[tv[v].id] = 1'b0;
      step();
      check("vec_idle_busy", busy, 0);
      check("vec_idle_ack", ack, 0);
      check("vec_reg_value", bank[tv[v].addr], tv[v].data);
    end

    // Reset asserted in the middle of DRIVE.
    do_reset();
    req_addr[3:2] = 2'd1; req_data[15:8] = 8'h5C; req[1] = 1'b1;
    step();
    check("rstmid_pre_s", s_out, 8'h5C);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_s", s_out, 0);
    check("rstmid_r", r_out, 0);
    check("rstmid_sel", reg_sel, 0);
    check("rstmid_busy", busy, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rstmid_no_ack", ack, 0);
    end

    // All four request at once after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*2 +: 2] = 2'(i);
      req_data[i*8 +: 8] = 8'(8'h11 * (i + 1) + 8'h80);
    end
    req = 4'b1111;
    ord.delete(); at.delete();
    for (int c = 1; c <= 12; c++) begin
      step();
      for (int i = 0; i < 4; i++) if (ack[i]) begin ord.push_back(i); at.push_back(c); req[i] = 1'b0; end
    end
    check("all4_nacks", ord.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ord.size()) begin
        check("all4_order", ord[k], k);
        check("all4_cycle", at[k], 2 + 3*k);
      end
    end
    step();
    for (int i = 0; i < 4; i++) check("all4_reg", bank[i], 8'(8'h11 * (i + 1) + 8'h80));

    // Two requesters held continuously alternate.
    do_reset();
    req = 4'b0101;
    ord.delete(); at.delete();
    for (int c = 1; c <= 12; c++) begin
      step();
      for (int i = 0; i < 4; i++) if (ack[i]) begin ord.push_back(i); at.push_back(c); end
    end
    req = '0;
    check("alt_nacks", ord.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ord.size()) begin
        check("alt_order", ord[k], (k % 2) * 2);
        check("alt_cycle", at[k], 2 + 3*k);
      end
    end
    step(); step(); step();

    // Readback mismatch, clear, and clear colliding with a new mismatch.
    do_reset();
    force_q = 1'b1; force_val = 8'h00;
    req_addr[7:6] = 2'd3; req_data[31:24] = 8'hFF; req[3] = 1'b1;
    step(); step();
    check("err_ack", ack, 4'b1000);
    req[3] = 1'b0;
    step();
    check("err_set", err, 1);
    check("err_id", err_id, 3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_cleared", err, 0);
    req[3] = 1'b1;
    step(); step();
    err_clr = 1'b1;
    req[3] = 1'b0;
    step();
    err_clr = 1'b0;
    check("err_set_wins", err, 1);
    check("err_id_again", err_id, 3);
    force_q = 1'b0;

    // Request dropped during DRIVE still completes; pointer moves past it.
    do_reset();
    req_addr[3:2] = 2'd1; req_data[15:8] = 8'h3C; req[1] = 1'b1;
    step();
    req[1] = 1'b0; req_data[15:8] = 8'h99;
    check("drop_drive_s", s_out, 8'h3C);
    step();
    check("drop_ack", ack, 4'b0010);
    step();
    check("drop_reg", bank[1], 8'h3C);
    req_addr[5:4] = 2'd2; req_data[23:16] = 8'h77;
    req[1] = 1'b1; req[2] = 1'b1;
    step(); step();
    check("ptr_adv_ack", ack, 4'b0100);
    req[2] = 1'b0;
    step(); step(); step();
    check("ptr_next_ack", ack, 4'b0010);
    req[1] = 1'b0;
    step();

    // Randomised traffic against the reference model.
    do_reset();
    m_phase = 0; m_ptr = 0;
    for (int a = 0; a < 4; a++) begin m_written[a] = 1'b0; m_done[a] = 1'b0; end
    rand_on = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (m_done[i]) begin
          req[i] = 1'b0;
          m_done[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req_addr[i*2 +: 2] = 2'($urandom_range(0, 3));
          req_data[i*8 +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    repeat (4) step();
    rand_on = 1'b0;
    for (int a = 0; a < 4; a++) if (m_written[a]) check("rnd_reg", bank[a], m_mem[a]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
